tx_rsio: RTL and testbench

TX_RSIO -- requirements
Module: tx_rsio

---
 rtl/tx_rsio_if.sv | 11 +
 rtl/tx_rsio.sv | 122 ++++++++++++
 tb/tb_tx_rsio.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/tx_rsio_if.sv
// MAC-side word handshake into tx_rsio. The MAC drives a 64-bit word with
// per-byte control flags; the serializer accepts it when tx_ready is high.
interface tx_rsio_if;
  logic [63:0] txd64;
  logic [7:0]  txc8;
  logic        tx_valid;
  logic        tx_ready;

  modport master (output txd64, output txc8, output tx_valid, input tx_ready);
  modport slave  (input txd64, input txc8, input tx_valid, output tx_ready);
endinterface

// File: rtl/tx_rsio.sv
// tx_rsio: splits 64-bit MAC words into two 32-bit XGMII columns, low column first.
// Optional link-fault sequencing is compiled in with `define TXRS_LINK_FAULT_EN.
module tx_rsio #(
  parameter int TP = 1
) (
  input  logic        txclk,
  input  logic        reset,
  tx_rsio_if.slave    mac,
  input  logic        local_fault,
  input  logic        remote_fault,
  output logic [31:0] txd_out,
  output logic [3:0]  txc_out,
  output logic [1:0]  link_status
);

  typedef enum logic [1:0] {
    ST_OK = 2'b00,
    ST_LF = 2'b01,
    ST_RF = 2'b10
  } state_e;

  // Columns are packed as {ctrl[3:0], data[31:0]}
  localparam logic [35:0] COL_IDLE = {4'hF, 32'h0707_0707};
  localparam logic [35:0] COL_RFLT = {4'h1, 32'h0200_009C};

  function automatic logic [35:0] col_ovr(input state_e st, input logic [35:0] col);
    case (st)
      ST_LF:   col_ovr = COL_RFLT;
      ST_RF:   col_ovr = COL_IDLE;
      default: col_ovr = col;
    endcase
  endfunction

  // TP has no effect on zero-delay synthesizable registers.
  logic unused_tp;
  assign unused_tp = (TP != 0);

  logic        phase_q;
  logic [35:0] out_q;
  logic [35:0] hold_q;
  logic [35:0] sel_lo;
  logic [35:0] sel_hi;
  logic [35:0] col_d;
  state_e      st_cur;

  assign mac.tx_ready = ~phase_q;

  always_comb begin
    if (mac.tx_valid) begin
      sel_lo = {mac.txc8[3:0], mac.txd64[31:0]};
      sel_hi = {mac.txc8[7:4], mac.txd64[63:32]};
    end else begin
      sel_lo = COL_IDLE;
      sel_hi = COL_IDLE;
    end
  end

`ifdef TXRS_LINK_FAULT_EN
  state_e     state_q;
  state_e     state_d;
  logic [6:0] cnt_q;
  logic [6:0] cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (local_fault) begin
      state_d = ST_LF;
      cnt_d   = 7'd0;
    end else if (remote_fault) begin
      state_d = ST_RF;
      cnt_d   = 7'd0;
    end else if (state_q != ST_OK) begin
      if (cnt_q == 7'd127) begin
        state_d = ST_OK;
        cnt_d   = 7'd0;
      end else begin
        cnt_d = cnt_q + 7'd1;
      end
    end
  end

  always_ff @(posedge txclk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_OK;
      cnt_q   <= 7'd0;
    end else if (!phase_q) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Low column uses the state being entered so both columns of a word agree.
  assign st_cur      = phase_q ? state_q : state_d;
  assign link_status = state_q;
`else
  logic unused_faults;
  assign unused_faults = local_fault ^ remote_fault;
  assign st_cur        = ST_OK;
  assign link_status   = 2'b00;
`endif

  assign col_d = phase_q ? col_ovr(st_cur, hold_q) : col_ovr(st_cur, sel_lo);

  always_ff @(posedge txclk or negedge reset) begin
    if (!reset) begin
      phase_q <= 1'b0;
      out_q   <= COL_IDLE;
      hold_q  <= COL_IDLE;
    end else begin
      phase_q <= ~phase_q;
      out_q   <= col_d;
      if (!phase_q) begin
        hold_q <= sel_hi;
      end
    end
  end

  assign txc_out = out_q[35:32];
  assign txd_out = out_q[31:0];

endmodule

// File: tb/tb_tx_rsio.sv
// Randomized bench for tx_rsio against a word-level model: expected columns
// are queued per accepted word and the fault state is derived from the last fault pulse.
module tb_tx_rsio;

  logic        txclk;
  logic        reset;
  logic        local_fault;
  logic        remote_fault;
  logic [31:0] txd_out;
  logic [3:0]  txc_out;
  logic [1:0]  link_status;

  tx_rsio_if bus();

  tx_rsio #(.TP(1)) dut (
    .txclk        (txclk),
    .reset        (reset),
    .mac          (bus),
    .local_fault  (local_fault),
    .remote_fault (remote_fault),
    .txd_out      (txd_out),
    .txc_out      (txc_out),
    .link_status  (link_status)
  );

  initial txclk = 1'b0;
  always #5 txclk = ~txclk;

  localparam logic [35:0] IDLE = {4'hF, 32'h0707_0707};
  localparam logic [35:0] RFLT = {4'h1, 32'h0200_009C};

  int          n_vec = 0;
  int          n_err = 0;
  logic [35:0] exp_q[$];
  bit          m_phase;
  int          m_word;
  int          m_last;
  int          m_kind;
  bit          m_have;
  logic [1:0]  m_link;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_phase = 1'b0;
    m_word  = 0;
    m_last  = 0;
    m_kind  = 0;
    m_have  = 1'b0;
    m_link  = 2'b00;
  endtask

  // One clock: predict the coming edge, let it happen, check at the falling edge.
  task automatic step();
    logic [35:0] lo, hi, e;
    int          st;
    if (!m_phase) begin
      st = 0;
`ifdef TXRS_LINK_FAULT_EN
      if (local_fault) begin
        m_kind = 1; m_last = m_word; m_have = 1'b1;
      end else if (remote_fault) begin
        m_kind = 2; m_last = m_word; m_have = 1'b1;
      end
      if (m_have && (m_word - m_last) <= 127) st = m_kind;
`endif
      m_link = 2'(st);
      if (bus.tx_valid) begin
        lo = {bus.txc8[3:0], bus.txd64[31:0]};
        hi = {bus.txc8[7:4], bus.txd64[63:32]};
      end else begin
        lo = IDLE;
        hi = IDLE;
      end
      if (st == 1) begin lo = RFLT; hi = RFLT; end
      if (st == 2) begin lo = IDLE; hi = IDLE; end
      exp_q.push_back(lo);
      exp_q.push_back(hi);
      m_word++;
    end
    m_phase = ~m_phase;
    @(posedge txclk);
    @(negedge txclk);
    if (exp_q.size() == 0) begin
      chk("queue_underrun", 64'd1, 64'd0);
      e = IDLE;
    end else begin
      e = exp_q.pop_front();
    end
    chk("txd", {32'd0, txd_out}, {32'd0, e[31:0]});
    chk("txc", {60'd0, txc_out}, {60'd0, e[35:32]});
    chk("ready", {63'd0, bus.tx_ready}, {63'd0, ~m_phase});
    chk("link", {62'd0, link_status}, {62'd0, m_link});
  endtask

  task automatic drive_idle();
    bus.tx_valid = 1'b0;
    bus.txd64    = 64'd0;
    bus.txc8     = 8'd0;
    local_fault  = 1'b0;
    remote_fault = 1'b0;
  endtask

  task automatic drive_rand(input int pct_valid);
    bus.tx_valid = ($urandom_range(0, 99) < pct_valid);
    bus.txd64    = {$urandom, $urandom};
    bus.txc8     = 8'($urandom);
  endtask

  task automatic align();
    drive_idle();
    while (m_phase) step();
  endtask

  task automatic run_words(input int n);
    local_fault  = 1'b0;
    remote_fault = 1'b0;
    for (int i = 0; i < 2 * n; i++) begin
      drive_rand(70);
      step();
    end
  endtask

  // Called at a falling edge; leaves reset released at a falling edge.
  task automatic apply_reset();
    reset = 1'b0;
    #1;
    chk("rst_txd", {32'd0, txd_out}, {32'd0, 32'h0707_0707});
    chk("rst_txc", {60'd0, txc_out}, 64'hF);
    chk("rst_ready", {63'd0, bus.tx_ready}, 64'd1);
    chk("rst_link", {62'd0, link_status}, 64'd0);
    @(negedge txclk);
    @(negedge txclk);
    chk("rst_hold_txd", {32'd0, txd_out}, {32'd0, 32'h0707_0707});
    chk("rst_hold_ready", {63'd0, bus.tx_ready}, 64'd1);
    reset = 1'b1;
    model_clear();
  endtask

  initial begin
    reset = 1'b0;
    drive_idle();
    model_clear();
    @(negedge txclk);
    apply_reset();

    // Idle after reset
    for (int i = 0; i < 8; i++) step();

    // Directed word
    align();
    bus.tx_valid = 1'b1;
    bus.txd64    = 64'h1122_3344_5566_7788;
    bus.txc8     = 8'h00;
    step();
    chk("dir_lo", {32'd0, txd_out}, {32'd0, 32'h5566_7788});
    chk("dir_lo_c", {60'd0, txc_out}, 64'd0);
    drive_idle();
    step();
    chk("dir_hi", {32'd0, txd_out}, {32'd0, 32'h1122_3344});
    chk("dir_hi_c", {60'd0, txc_out}, 64'd0);

    run_words(100);

    // Single local fault pulse
    align();
    local_fault = 1'b1;
    drive_rand(100);
    step();
`ifdef TXRS_LINK_FAULT_EN
    chk("lf_link", {62'd0, link_status}, 64'd1);
    chk("lf_txd", {32'd0, txd_out}, {32'd0, 32'h0200_009C});
`else
    chk("lf_link", {62'd0, link_status}, 64'd0);
    chk("lf_txd", {32'd0, txd_out}, {32'd0, bus.txd64[31:0]});
`endif
    run_words(135);

    // Remote fault, then local fault during RF
    align();
    remote_fault = 1'b1;
    step();
`ifdef TXRS_LINK_FAULT_EN
    chk("rf_link", {62'd0, link_status}, 64'd2);
`endif
    run_words(20);
    align();
    local_fault = 1'b1;
    step();
    run_words(140);

    // Both faults together, re-pulse after 100 quiet words
    align();
    local_fault  = 1'b1;
    remote_fault = 1'b1;
    step();
`ifdef TXRS_LINK_FAULT_EN
    chk("both_link", {62'd0, link_status}, 64'd1);
`endif
    run_words(101);
    align();
    remote_fault = 1'b1;
    step();
    run_words(140);

    // Sparse random faults with random traffic
    for (int i = 0; i < 1200; i++) begin
      drive_rand(80);
      local_fault  = ($urandom_range(0, 299) == 0);
      remote_fault = ($urandom_range(0, 299) == 0);
      step();
    end
    run_words(130);

    // Reset while the high column is held
    align();
    bus.tx_valid = 1'b1;
    bus.txd64    = 64'hDEAD_BEEF_CAFE_F00D;
    bus.txc8     = 8'h5A;
    step();
    apply_reset();
    drive_idle();
    step();
    chk("no_stale_hi", {32'd0, txd_out}, {32'd0, 32'h0707_0707});
    run_words(50);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
